// File: rtl/vec_mul_ctrl.sv
// vec_mul_ctrl: sequencing controller for the 1xN vector-multiplier datapath.
//
// The controller does four jobs:
//   - Builds the full weight matrix from row-wise beats. The first beat is
//     written to the most-significant row.
//   - Pulses dp_weight_reload for one cycle once the matrix is complete.
//   - Streams input rows into the datapath under valid/ready and tracks the
//     rows in flight through the fixed datapath latency.
//   - Buffers datapath results in a first-word-fall-through FIFO. The
//     datapath cannot stall, so a row is only admitted when a FIFO slot is
//     guaranteed for its result.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   w_valid/w_ready      weight row beat handshake, w_row = one weight row
//   in_valid/in_ready    input row handshake, in_data = one input row
//   out_valid/out_ready  result row handshake, out_data = FIFO head
//   dp_weight_reload     one-cycle reload strobe to the datapath
//   dp_weights           assembled weight matrix to the datapath
//   dp_data_in           registered input row to the datapath
//   dp_data_out          result row from the datapath
//   busy                 rows in flight or FIFO not empty
module vec_mul_ctrl #(
    parameter int WEIGHT_BW      = 8,
    parameter int DATA_BW        = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8,
    parameter int PE_LATENCY     = 1,
    parameter int OUT_DEPTH      = 4
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic                                        w_valid,
    output logic                                        w_ready,
    input  logic [WEIGHT_BW*MATRIX_SIZE-1:0]            w_row,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DATA_BW*MATRIX_SIZE-1:0]              in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]       out_data,
    output logic                                        dp_weight_reload,
    output logic [WEIGHT_BW*MATRIX_SIZE*MATRIX_SIZE-1:0] dp_weights,
    output logic [DATA_BW*MATRIX_SIZE-1:0]              dp_data_in,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]       dp_data_out,
    output logic                                        busy
);

    localparam int ROW_W  = WEIGHT_BW * MATRIX_SIZE;
    localparam int IN_W   = DATA_BW * MATRIX_SIZE;
    localparam int OUT_W  = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int MAT_W  = ROW_W * MATRIX_SIZE;
    localparam int CNT_W  = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int FCNT_W = $clog2(OUT_DEPTH + 1);
    localparam int IFC_W  = $clog2(PE_LATENCY + 1);
    localparam int SUM_W  = ((FCNT_W > IFC_W) ? FCNT_W : IFC_W) + 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RELOAD = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t                  state_r, state_next_s;
    logic [CNT_W-1:0]        row_cnt_r, row_cnt_next_s;
    logic [MAT_W-1:0]        weights_r, weights_next_s;
    logic [IN_W-1:0]         data_in_r, data_in_next_s;
    logic [PE_LATENCY-1:0]   inflight_r, inflight_next_s;
    logic [OUT_W-1:0]        fifo_mem_r [OUT_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
    logic [FCNT_W-1:0]       fifo_cnt_r;

    logic                    w_ready_s, in_ready_s;
    logic                    w_accept_s, in_accept_s;
    logic                    push_s, pop_s, out_valid_s, credit_ok_s;
    logic [IFC_W-1:0]        inflight_cnt_s;
    logic [SUM_W-1:0]        occupancy_s;

    // Number of issued rows still travelling through the datapath.
    function automatic logic [IFC_W-1:0] popcount(input logic [PE_LATENCY-1:0] v);
        logic [IFC_W-1:0] c;
        c = {IFC_W{1'b0}};
        for (int i = 0; i < PE_LATENCY; i++) begin
            c = c + IFC_W'(v[i]);
        end
        return c;
    endfunction

    // FIFO pointer advance with wrap at OUT_DEPTH (depth need not be 2^n).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(OUT_DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    // Credit: every row in flight or buffered owns one FIFO slot; a pop in
    // the current cycle is deliberately not credited.
    always_comb begin
        inflight_cnt_s = popcount(inflight_r);
        occupancy_s    = {{(SUM_W-IFC_W){1'b0}}, inflight_cnt_s}
                       + {{(SUM_W-FCNT_W){1'b0}}, fifo_cnt_r};
        credit_ok_s    = (occupancy_s < SUM_W'(OUT_DEPTH));
    end

    // Next-state logic and handshake readies for the sequencing FSM.
    always_comb begin
        state_next_s   = state_r;
        row_cnt_next_s = row_cnt_r;
        w_ready_s      = 1'b0;
        in_ready_s     = 1'b0;
        case (state_r)
            ST_LOAD: begin
                w_ready_s = 1'b1;
                if (w_valid) begin
                    if (row_cnt_r == CNT_W'(MATRIX_SIZE - 1)) begin
                        row_cnt_next_s = {CNT_W{1'b0}};
                        state_next_s   = ST_RELOAD;
                    end else begin
                        row_cnt_next_s = row_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_RELOAD: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                // A new weight load request closes the input stream at once.
                if (w_valid) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    in_ready_s = credit_ok_s;
                end
            end
            ST_DRAIN: begin
                if (inflight_cnt_s == {IFC_W{1'b0}}) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s   = ST_LOAD;
                row_cnt_next_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Datapath-side next values: weight row write, input row capture and
    // the in-flight valid shift register.
    always_comb begin
        w_accept_s     = w_valid && w_ready_s;
        in_accept_s    = in_valid && in_ready_s;
        weights_next_s = weights_r;
        for (int k = 0; k < MATRIX_SIZE; k++) begin
            if (w_accept_s && (row_cnt_r == CNT_W'(k))) begin
                weights_next_s[(MATRIX_SIZE-k)*ROW_W-1 -: ROW_W] = w_row;
            end else begin
                weights_next_s[(MATRIX_SIZE-k)*ROW_W-1 -: ROW_W] =
                    weights_r[(MATRIX_SIZE-k)*ROW_W-1 -: ROW_W];
            end
        end
        if (in_accept_s) begin
            data_in_next_s = in_data;
        end else begin
            data_in_next_s = data_in_r;
        end
        inflight_next_s    = inflight_r;
        inflight_next_s[0] = in_accept_s;
        for (int i = 1; i < PE_LATENCY; i++) begin
            inflight_next_s[i] = inflight_r[i-1];
        end
    end

    // The oldest in-flight bit marks the cycle its result is on dp_data_out.
    always_comb begin
        out_valid_s = (fifo_cnt_r != {FCNT_W{1'b0}});
        push_s      = inflight_r[PE_LATENCY-1];
        pop_s       = out_valid_s && out_ready;
    end

    // Control and datapath-facing registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= ST_LOAD;
            row_cnt_r  <= {CNT_W{1'b0}};
            weights_r  <= {MAT_W{1'b0}};
            data_in_r  <= {IN_W{1'b0}};
            inflight_r <= {PE_LATENCY{1'b0}};
        end else begin
            state_r    <= state_next_s;
            row_cnt_r  <= row_cnt_next_s;
            weights_r  <= weights_next_s;
            data_in_r  <= data_in_next_s;
            inflight_r <= inflight_next_s;
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_mem_r[i] <= {OUT_W{1'b0}};
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {FCNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= dp_data_out;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + {{(FCNT_W-1){1'b0}}, 1'b1};
                2'b01:   fifo_cnt_r <= fifo_cnt_r - {{(FCNT_W-1){1'b0}}, 1'b1};
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    assign w_ready          = w_ready_s;
    assign in_ready         = in_ready_s;
    assign out_valid        = out_valid_s;
    assign out_data         = fifo_mem_r[rd_ptr_r];
    assign dp_weight_reload = (state_r == ST_RELOAD);
    assign dp_weights       = weights_r;
    assign dp_data_in       = data_in_r;
    assign busy             = (inflight_cnt_s != {IFC_W{1'b0}}) || out_valid_s;

endmodule

// File: tb/tb_vec_mul_ctrl.sv
// Directed testbench for vec_mul_ctrl with a combinational datapath stub
// (PE_LATENCY = 1) that computes out[j] = sum_i in[i] * W[i][j].
module tb_vec_mul_ctrl;

    localparam int MS  = 8;
    localparam int WW  = 64;
    localparam int IW  = 64;
    localparam int OW  = 160;
    localparam int MW  = 512;

    logic          clk;
    logic          rstn;
    logic          w_valid;
    logic          w_ready;
    logic [WW-1:0] w_row;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          dp_weight_reload;
    logic [MW-1:0] dp_weights;
    logic [IW-1:0] dp_data_in;
    logic [OW-1:0] dp_data_out;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WW-1:0] wbuf [MS];
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] got_q [$];
    logic          last_acc;
    logic          last_wacc;
    int            acc_cnt;
    int            pop_cnt;
    int            cyc;
    int            first_acc_cyc;
    int            first_ov_cyc;
    int            outstanding;
    int            max_outstanding;

    vec_mul_ctrl dut (
        .clk              (clk),
        .rstn             (rstn),
        .w_valid          (w_valid),
        .w_ready          (w_ready),
        .w_row            (w_row),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .dp_weight_reload (dp_weight_reload),
        .dp_weights       (dp_weights),
        .dp_data_in       (dp_data_in),
        .dp_data_out      (dp_data_out),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stub: weight row i sits at dp_weights[(MS-1-i)*64 +: 64].
    logic [19:0] acc_s;
    always_comb begin
        dp_data_out = '0;
        acc_s       = 20'd0;
        for (int j = 0; j < MS; j++) begin
            acc_s = 20'd0;
            for (int i = 0; i < MS; i++) begin
                acc_s = acc_s + 20'(dp_weights[(MS-1-i)*64 + j*8 +: 8]) * 20'(dp_data_in[i*8 +: 8]);
            end
            dp_data_out[j*20 +: 20] = acc_s;
        end
    end

    // Identity weights: each result element is the input byte zero-extended.
    function automatic logic [OW-1:0] ext(input logic [IW-1:0] d);
        logic [OW-1:0] r;
        r = '0;
        for (int j = 0; j < MS; j++) r[j*20 +: 20] = {12'd0, d[j*8 +: 8]};
        return r;
    endfunction

    task automatic clear_counters();
        exp_q.delete();
        got_q.delete();
        last_acc = 1'b0; last_wacc = 1'b0;
        acc_cnt = 0; pop_cnt = 0; cyc = 0;
        first_acc_cyc = -1; first_ov_cyc = -1;
        outstanding = 0; max_outstanding = 0;
    endtask

    // Record the transfers of the current cycle, then advance one edge.
    task automatic tick();
        logic pop;
        #1;
        last_acc  = in_valid && in_ready;
        last_wacc = w_valid && w_ready;
        pop       = out_valid && out_ready;
        if (last_acc) begin
            exp_q.push_back(ext(in_data));
            acc_cnt++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (pop) begin
            got_q.push_back(out_data);
            pop_cnt++;
        end
        outstanding = outstanding + int'(last_acc) - int'(pop);
        if (outstanding > max_outstanding) max_outstanding = outstanding;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; w_valid = 1'b0; w_row = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_counters();
    endtask

    // Present wbuf[0..7]; optionally idle one cycle after beat gap_after.
    task automatic load_weights(input int gap_after);
        int guard;
        for (int k = 0; k < MS; k++) begin
            w_valid = 1'b1;
            w_row   = wbuf[k];
            guard   = 0;
            tick();
            while (!last_wacc && guard < 40) begin
                tick();
                guard++;
            end
            n_cmp++;
            if (last_wacc !== 1'b1) begin
                n_fail++;
                $display("FAIL load_beat_%0d: accepted=%b, required 1 within 40 cycles", k, last_wacc);
            end
            w_valid = 1'b0;
            if (k == gap_after) tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic set_identity();
        for (int k = 0; k < MS; k++) wbuf[k] = 64'd1 << (8*k);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL reset_w_ready: got %b want 1", w_ready); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (dp_weight_reload !== 1'b0) begin n_fail++; $display("FAIL reset_reload: got %b want 0", dp_weight_reload); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (dp_weights !== '0) begin n_fail++; $display("FAIL reset_weights: got %h want 0", dp_weights); end
        n_cmp++; if (dp_data_in !== '0) begin n_fail++; $display("FAIL reset_data_in: got %h want 0", dp_data_in); end
    endtask

    task automatic test_load();
        do_reset();
        for (int k = 0; k < MS; k++) wbuf[k] = {8{8'(k + 1)}};
        load_weights(3);
        n_cmp++; if (dp_weight_reload !== 1'b1) begin n_fail++; $display("FAIL load_reload_pulse: got %b want 1", dp_weight_reload); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_in_ready_reload: got %b want 0", in_ready); end
        n_cmp++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL load_w_ready_reload: got %b want 0", w_ready); end
        n_cmp++; if (dp_weights[511:448] !== 64'h0101010101010101) begin n_fail++; $display("FAIL load_row0: got %h want 0101010101010101", dp_weights[511:448]); end
        n_cmp++; if (dp_weights[319:256] !== 64'h0404040404040404) begin n_fail++; $display("FAIL load_row3: got %h want 0404040404040404", dp_weights[319:256]); end
        n_cmp++; if (dp_weights[63:0] !== 64'h0808080808080808) begin n_fail++; $display("FAIL load_row7: got %h want 0808080808080808", dp_weights[63:0]); end
        tick();
        n_cmp++; if (dp_weight_reload !== 1'b0) begin n_fail++; $display("FAIL load_reload_width: got %b want 0", dp_weight_reload); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_in_ready_run: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int guard;
        do_reset();
        set_identity();
        load_weights(-1);
        tick();
        clear_counters();
        out_ready = 1'b1;
        for (int r = 0; r < 10; r++) begin
            in_valid = 1'b1;
            in_data  = {8{8'(r)}};
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (acc_cnt !== 10) begin n_fail++; $display("FAIL b2b_throughput: got %0d accepts want 10", acc_cnt); end
        guard = 0;
        while (busy && guard < 20) begin tick(); guard++; end
        tick();
        n_cmp++; if (got_q.size() !== 10) begin n_fail++; $display("FAIL b2b_count: got %0d want 10", got_q.size()); end
        for (int r = 0; r < 10 && r < got_q.size(); r++) begin
            n_cmp++;
            if (got_q[r] !== ext({8{8'(r)}})) begin n_fail++; $display("FAIL b2b_row_%0d: got %h want %h", r, got_q[r], ext({8{8'(r)}})); end
        end
        n_cmp++; if (first_ov_cyc - first_acc_cyc !== 2) begin n_fail++; $display("FAIL b2b_latency: got %0d want 2", first_ov_cyc - first_acc_cyc); end
        n_cmp++; if (dp_data_in !== {8{8'd9}}) begin n_fail++; $display("FAIL b2b_data_in_hold: got %h want %h", dp_data_in, {8{8'd9}}); end
    endtask

    task automatic test_backpressure();
        int guard;
        do_reset();
        set_identity();
        load_weights(-1);
        tick();
        clear_counters();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_data = {8{8'(8'h10 + 8'(acc_cnt))}};
            tick();
        end
        #1;
        n_cmp++; if (acc_cnt !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", acc_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (busy && guard < 20) begin tick(); guard++; end
        n_cmp++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL bp_drained: got %0d want 4", got_q.size()); end
        for (int r = 0; r < 4 && r < got_q.size(); r++) begin
            n_cmp++;
            if (got_q[r] !== ext({8{8'(8'h10 + 8'(r))}})) begin n_fail++; $display("FAIL bp_row_%0d: got %h want %h", r, got_q[r], ext({8{8'(8'h10 + 8'(r))}})); end
        end
    endtask

    task automatic test_reload_in_run();
        int guard;
        do_reset();
        set_identity();
        load_weights(-1);
        tick();
        clear_counters();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {8{8'h21}};
        tick();
        in_data   = {8{8'h22}};
        tick();
        in_data   = {8{8'h23}};
        for (int k = 0; k < MS; k++) wbuf[k] = {8{8'h02}};
        w_valid = 1'b1;
        w_row   = wbuf[0];
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rr_in_ready_drop: got %b want 0", in_ready); end
        n_cmp++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL rr_w_ready_run: got %b want 0", w_ready); end
        in_valid = 1'b0;
        load_weights(-1);
        n_cmp++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL rr_captured: got %0d want 2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_cmp++; if (got_q[0] !== ext({8{8'h21}})) begin n_fail++; $display("FAIL rr_row0: got %h want %h", got_q[0], ext({8{8'h21}})); end
            n_cmp++; if (got_q[1] !== ext({8{8'h22}})) begin n_fail++; $display("FAIL rr_row1: got %h want %h", got_q[1], ext({8{8'h22}})); end
        end
        n_cmp++; if (dp_weight_reload !== 1'b1) begin n_fail++; $display("FAIL rr_reload: got %b want 1", dp_weight_reload); end
        n_cmp++; if (dp_weights[63:0] !== {8{8'h02}}) begin n_fail++; $display("FAIL rr_new_weights: got %h want %h", dp_weights[63:0], {8{8'h02}}); end
        tick();
        clear_counters();
        in_valid = 1'b1;
        in_data  = {8{8'h01}};
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin tick(); guard++; end
        n_cmp++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL rr_new_result_count: got %0d want 1", got_q.size());
        end else if (got_q[0] !== {8{20'd16}}) begin
            n_fail++; $display("FAIL rr_new_result: got %h want %h", got_q[0], {8{20'd16}});
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_identity();
        load_weights(-1);
        tick();
        clear_counters();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int r = 0; r < 3; r++) begin
            in_data = {8{8'(8'h40 + 8'(r))}};
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mr_pre_state: got valid=%b busy=%b want 1 1", out_valid, busy); end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy: got %b want 0", busy); end
        n_cmp++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL mr_w_ready: got %b want 1", w_ready); end
        n_cmp++; if (dp_weights !== '0) begin n_fail++; $display("FAIL mr_weights: got %h want 0", dp_weights); end
        clear_counters();
        out_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (pop_cnt !== 0) begin n_fail++; $display("FAIL mr_no_stale_output: got %0d want 0", pop_cnt); end
    endtask

    task automatic test_random();
        int guard;
        do_reset();
        set_identity();
        load_weights(-1);
        tick();
        clear_counters();
        guard = 0;
        while (got_q.size() < 200 && guard < 6000) begin
            if (!in_valid || last_acc) begin
                if (acc_cnt < 200) begin
                    in_valid = ($urandom_range(9) < 7);
                    in_data  = {$urandom, $urandom};
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(9) < 6);
            tick();
            guard++;
        end
        in_valid = 1'b0;
        n_cmp++; if (got_q.size() !== 200) begin n_fail++; $display("FAIL rnd_count: got %0d want 200", got_q.size()); end
        n_cmp++; if (exp_q.size() !== 200) begin n_fail++; $display("FAIL rnd_accepted: got %0d want 200", exp_q.size()); end
        for (int r = 0; r < 200 && r < got_q.size() && r < exp_q.size(); r++) begin
            n_cmp++;
            if (got_q[r] !== exp_q[r]) begin n_fail++; $display("FAIL rnd_row_%0d: got %h want %h", r, got_q[r], exp_q[r]); end
        end
        n_cmp++; if (max_outstanding > 4) begin n_fail++; $display("FAIL rnd_overflow: max outstanding %0d, limit 4", max_outstanding); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_backpressure();
        test_reload_in_run();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
